// File: rtl/sub_rgb_sched.sv
// rtl/sub_rgb_sched.sv - two-source scheduler sharing one sub_RGB unit
// A tag pipeline mirrors the unit so each result returns with its source id.
module sub_rgb_sched #(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [9:0] req0_red,
  input  logic [9:0] req0_green,
  input  logic [9:0] req0_blue,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [9:0] req1_red,
  input  logic [9:0] req1_green,
  input  logic [9:0] req1_blue,
  output logic       sub_ce,
  output logic [9:0] sub_red,
  output logic [9:0] sub_green,
  output logic [9:0] sub_blue,
  input  logic [9:0] sub_value,
  input  logic [1:0] sub_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [9:0] res_value,
  output logic [1:0] res_index,
  output logic       res_src,
  output logic       busy
);

  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_src_q, tag_src_d;
  logic           last_q, last_d;
  logic           stall, elig0, elig1, win0, win1;

  assign res_valid = tag_v_q[LAT-1];
  assign res_src   = tag_src_q[LAT-1];
  assign res_value = sub_value;
  assign res_index = sub_index;
  assign busy      = |tag_v_q;

  // Only a real result can stall; a bubble at the output never blocks the unit.
  assign stall  = res_valid & ~res_ready;
  assign sub_ce = rst_n & ~stall;

  assign elig0 = req0_valid & en & sub_ce;
  assign elig1 = req1_valid & en & sub_ce;

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (mode) begin
      win0 = elig0;
      win1 = elig1 & ~elig0;
    end else if (elig0 && elig1) begin
      win0 = last_q;
      win1 = ~last_q;
    end else begin
      win0 = elig0;
      win1 = elig1;
    end
  end

  assign req0_ready = win0;
  assign req1_ready = win1;

  always_comb begin
    sub_red   = 10'd0;
    sub_green = 10'd0;
    sub_blue  = 10'd0;
    if (win0) begin
      sub_red   = req0_red;
      sub_green = req0_green;
      sub_blue  = req0_blue;
    end else if (win1) begin
      sub_red   = req1_red;
      sub_green = req1_green;
      sub_blue  = req1_blue;
    end
  end

  always_comb begin
    tag_v_d   = tag_v_q;
    tag_src_d = tag_src_q;
    last_d    = last_q;
    if (sub_ce) begin
      tag_v_d[0]   = win0 | win1;
      tag_src_d[0] = win1;
      for (int k = 1; k < LAT; k++) begin
        tag_v_d[k]   = tag_v_q[k-1];
        tag_src_d[k] = tag_src_q[k-1];
      end
      if (win0 || win1) last_d = win1;
    end
  end

  // last resets to 1 so source 0 takes the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q   <= '0;
      tag_src_q <= '0;
      last_q    <= 1'b1;
    end else begin
      tag_v_q   <= tag_v_d;
      tag_src_q <= tag_src_d;
      last_q    <= last_d;
    end
  end

endmodule
